mem_wb_stage: RTL and testbench

- Execute-side consumer of the ALU. Takes each completed ALU operation (result, NZCV flags, uop, destination register) and retires it.
- Retiring covers three things: latching architectural flags, performing the data-memory access for LDR/STR over a req/ack handshake, and issuing the register-file write.
- Multi-cycle stage with a valid/ready handshake toward the core sequencer.

---
 rtl/mem_wb_stage.sv | 156 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
//------------------------------------------------------------------------------
// Module     : mem_wb_stage
// Description: Retires ALU operations: architectural flags, LDR/STR memory
//              access over a req/ack handshake, and register-file writeback.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int NUM_REGS_LOG2  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_uop,
    input  logic [31:0]              in_result,
    input  logic [3:0]               in_flags,
    input  logic                     in_set_flags,
    input  logic [NUM_REGS_LOG2-1:0] in_rd,
    input  logic [31:0]              in_store_data,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ack,
    output logic                     reg_we,
    output logic [NUM_REGS_LOG2-1:0] reg_waddr,
    output logic [31:0]              reg_wdata,
    output logic [3:0]               flags_q,
    output logic                     done,
    output logic                     mem_fault
);

    localparam logic [4:0] UOP_ADD = 5'd0;
    localparam logic [4:0] UOP_SUB = 5'd1;
    localparam logic [4:0] UOP_AND = 5'd2;
    localparam logic [4:0] UOP_EOR = 5'd3;
    localparam logic [4:0] UOP_CMP = 5'd4;
    localparam logic [4:0] UOP_LSL = 5'd5;
    localparam logic [4:0] UOP_LSR = 5'd6;
    localparam logic [4:0] UOP_MOV = 5'd7;
    localparam logic [4:0] UOP_STR = 5'd8;
    localparam logic [4:0] UOP_LDR = 5'd9;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MEM    = 2'd1,
        S_WB     = 2'd2,
        S_RETIRE = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [3:0]               r_flags;
    logic                     r_fault;
    logic [31:0]              r_addr;
    logic [31:0]              r_store;
    logic [31:0]              r_res;
    logic [NUM_REGS_LOG2-1:0] r_rd;
    logic                     r_is_str;

    logic w_accept;
    logic w_is_mem;
    logic w_is_alu;
    logic w_aligned;
    logic w_timeout;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_is_mem  = (in_uop == UOP_LDR) || (in_uop == UOP_STR);
    assign w_is_alu  = (in_uop == UOP_ADD) || (in_uop == UOP_SUB) ||
                       (in_uop == UOP_AND) || (in_uop == UOP_EOR) ||
                       (in_uop == UOP_LSL) || (in_uop == UOP_LSR) ||
                       (in_uop == UOP_MOV);
    assign w_aligned = (in_result[1:0] == 2'b00);
    // A late ack on the last allowed cycle wins over the timeout.
    assign w_timeout = (r_state == S_MEM) && !mem_ack && (r_cnt == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mem)      w_next = w_aligned ? S_MEM : S_RETIRE;
                    else if (w_is_alu) w_next = S_WB;
                    else               w_next = S_RETIRE;
                end
            end
            S_MEM: begin
                if (mem_ack)        w_next = r_is_str ? S_RETIRE : S_WB;
                else if (w_timeout) w_next = S_RETIRE;
            end
            S_WB:     w_next = S_IDLE;
            S_RETIRE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_flags  <= 4'b0000;
            r_fault  <= 1'b0;
            r_addr   <= 32'd0;
            r_store  <= 32'd0;
            r_res    <= 32'd0;
            r_rd     <= '0;
            r_is_str <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rd     <= in_rd;
                r_addr   <= in_result;
                r_store  <= in_store_data;
                r_res    <= in_result;
                r_is_str <= (in_uop == UOP_STR);
                r_cnt    <= '0;
                if ((in_uop == UOP_CMP) || (in_set_flags && w_is_alu))
                    r_flags <= in_flags;
                if (w_is_mem && !w_aligned)
                    r_fault <= 1'b1;
            end
            if (r_state == S_MEM) begin
                if (mem_ack) begin
                    if (!r_is_str) r_res <= mem_rdata;
                end else if (w_timeout) begin
                    r_fault <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign mem_req   = (r_state == S_MEM);
    assign mem_we    = (r_state == S_MEM) && r_is_str;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_store;
    assign reg_we    = (r_state == S_WB);
    assign reg_waddr = r_rd;
    assign reg_wdata = r_res;
    assign flags_q   = r_flags;
    assign done      = (r_state == S_WB) || (r_state == S_RETIRE);
    assign mem_fault = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
//------------------------------------------------------------------------------
// Module     : tb_mem_wb_stage
// Description: Directed self-checking bench for mem_wb_stage.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_stage;

    localparam logic [4:0] ADD = 5'd0;
    localparam logic [4:0] SUB = 5'd1;
    localparam logic [4:0] CMP = 5'd4;
    localparam logic [4:0] STR = 5'd8;
    localparam logic [4:0] LDR = 5'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_uop;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic        in_set_flags;
    logic [3:0]  in_rd;
    logic [31:0] in_store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [3:0]  flags_q;
    logic        done;
    logic        mem_fault;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_stage #(.TIMEOUT_CYCLES(8), .NUM_REGS_LOG2(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
        .in_result(in_result), .in_flags(in_flags), .in_set_flags(in_set_flags),
        .in_rd(in_rd), .in_store_data(in_store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .flags_q(flags_q), .done(done), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    // Presents one op, waits for in_ready (bounded), returns #1 after the accept edge.
    task automatic accept(input logic [4:0] uop, input logic [31:0] res,
                          input logic [3:0] fl, input logic sf,
                          input logic [3:0] rd, input logic [31:0] sd);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_bad++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_uop = uop; in_result = res; in_flags = fl;
        in_set_flags = sf; in_rd = rd; in_store_data = sd;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_cmp++; if ({mem_req, mem_we, reg_we, done} !== 4'b0000) begin n_bad++; $display("FAIL reset_strobes: got %b required 0000", {mem_req, mem_we, reg_we, done}); end
        n_cmp++; if ({flags_q, mem_fault} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b required 00000", {flags_q, mem_fault}); end
        n_cmp++; if ({mem_addr, mem_wdata, reg_wdata} !== 96'd0) begin n_bad++; $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, reg_wdata}); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_alu;
        accept(ADD, 32'h5, 4'b0000, 1'b1, 4'd3, 32'h0);
        n_cmp++; if ({reg_we, done, in_ready} !== 3'b110) begin n_bad++; $display("FAIL add_wb: we/done/ready=%b required 110", {reg_we, done, in_ready}); end
        n_cmp++; if (reg_waddr !== 4'd3 || reg_wdata !== 32'h5) begin n_bad++; $display("FAIL add_data: got %0d/%h required 3/00000005", reg_waddr, reg_wdata); end
        n_cmp++; if (flags_q !== 4'b0000) begin n_bad++; $display("FAIL add_flags: got %b required 0000", flags_q); end
        @(posedge clk); #1;
        n_cmp++; if ({reg_we, done, in_ready} !== 3'b001) begin n_bad++; $display("FAIL add_idle: we/done/ready=%b required 001", {reg_we, done, in_ready}); end
    endtask

    task automatic test_flags;
        accept(CMP, 32'h0, 4'b0110, 1'b0, 4'd1, 32'h0);
        n_cmp++; if (flags_q !== 4'b0110) begin n_bad++; $display("FAIL cmp_flags: got %b required 0110", flags_q); end
        n_cmp++; if ({reg_we, done} !== 2'b01) begin n_bad++; $display("FAIL cmp_retire: we/done=%b required 01", {reg_we, done}); end
        accept(SUB, 32'h9, 4'b1000, 1'b0, 4'd2, 32'h0);
        n_cmp++; if (flags_q !== 4'b0110) begin n_bad++; $display("FAIL sub_noset: got %b required 0110", flags_q); end
        n_cmp++; if (reg_we !== 1'b1 || reg_wdata !== 32'h9) begin n_bad++; $display("FAIL sub_wb: got %b/%h required 1/00000009", reg_we, reg_wdata); end
        accept(5'd31, 32'h7, 4'b1111, 1'b1, 4'd4, 32'h0);
        n_cmp++; if ({reg_we, done, flags_q} !== 6'b010110) begin n_bad++; $display("FAIL unknown_uop: we/done/flags=%b required 010110", {reg_we, done, flags_q}); end
    endtask

    task automatic test_load;
        logic ok;
        accept(LDR, 32'h100, 4'b1111, 1'b1, 4'd7, 32'h0);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || reg_we !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ldr_wait: req/we/addr=%b/%b/%h required 1/0/00000100", mem_req, mem_we, mem_addr); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_bad++; $display("FAIL ldr_ack_cycle: req/addr=%b/%h required 1/00000100", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_cmp++; if ({reg_we, done, mem_req} !== 3'b110) begin n_bad++; $display("FAIL ldr_wb: we/done/req=%b required 110", {reg_we, done, mem_req}); end
        n_cmp++; if (reg_waddr !== 4'd7 || reg_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ldr_data: got %0d/%h required 7/deadbeef", reg_waddr, reg_wdata); end
        n_cmp++; if (flags_q !== 4'b0110) begin n_bad++; $display("FAIL ldr_flags: got %b required 0110", flags_q); end
    endtask

    task automatic test_store_and_misalign;
        accept(STR, 32'h40, 4'b0000, 1'b0, 4'd5, 32'h12345678);
        n_cmp++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin n_bad++; $display("FAIL str_req: req/we/addr/wdata=%b/%b/%h/%h required 1/1/00000040/12345678", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_cmp++; if ({reg_we, done, mem_req} !== 3'b010) begin n_bad++; $display("FAIL str_retire: we/done/req=%b required 010", {reg_we, done, mem_req}); end
        accept(LDR, 32'h102, 4'b0000, 1'b0, 4'd6, 32'h0);
        n_cmp++; if ({mem_req, reg_we, done, mem_fault} !== 4'b0011) begin n_bad++; $display("FAIL ldr_misalign: req/we/done/fault=%b required 0011", {mem_req, reg_we, done, mem_fault}); end
    endtask

    task automatic test_reset_mid_mem;
        accept(LDR, 32'h200, 4'b0000, 1'b0, 4'd9, 32'h0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_cmp++; if ({mem_req, flags_q, mem_fault} !== 6'b0) begin n_bad++; $display("FAIL rst_abort: req/flags/fault=%b required 000000", {mem_req, flags_q, mem_fault}); end
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_cmp++; if ({in_ready, reg_we, done, mem_req} !== 4'b1000) begin n_bad++; $display("FAIL rst_late_ack: ready/we/done/req=%b required 1000", {in_ready, reg_we, done, mem_req}); end
    endtask

    task automatic test_timeout;
        int n;
        accept(LDR, 32'h300, 4'b0000, 1'b0, 4'd8, 32'h0);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL timeout_len: req high %0d cycles required 8", n); end
        n_cmp++; if ({mem_fault, done, reg_we} !== 3'b110) begin n_bad++; $display("FAIL timeout_retire: fault/done/we=%b required 110", {mem_fault, done, reg_we}); end
        accept(ADD, 32'hA5A5, 4'b1001, 1'b1, 4'd2, 32'h0);
        n_cmp++; if ({reg_we, done, mem_fault} !== 3'b111 || reg_wdata !== 32'hA5A5 || flags_q !== 4'b1001) begin n_bad++; $display("FAIL after_fault_add: we/done/fault=%b data=%h flags=%b required 111/0000a5a5/1001", {reg_we, done, mem_fault}, reg_wdata, flags_q); end
    endtask

    initial begin
        in_valid = 1'b0; in_uop = 5'd0; in_result = 32'd0; in_flags = 4'd0;
        in_set_flags = 1'b0; in_rd = 4'd0; in_store_data = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        test_reset();
        test_alu();
        test_flags();
        test_load();
        test_store_and_misalign();
        test_reset_mid_mem();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
